// File: rtl/mode_counter.sv
// rtl/mode_counter.sv - bounded up/down counter with wrap/saturate modes
// Optional en-cycle prescaler is built when COUNTER_PRESCALE_EN is defined.
module mode_counter #(
    parameter int          DATA_WIDTH = 8,
    parameter int unsigned RESET_VAL  = 0,
    parameter int          PRESCALE   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  clear,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_val,
    input  logic                  dir,
    input  logic [DATA_WIDTH-1:0] step,
    input  logic [DATA_WIDTH-1:0] min_val,
    input  logic [DATA_WIDTH-1:0] max_val,
    input  logic                  wrap,
    output logic [DATA_WIDTH-1:0] out,
    output logic                  tc,
    output logic                  sat
);

    logic [DATA_WIDTH:0] up_sum;
    logic [DATA_WIDTH:0] dn_lim;
    logic                bounds_ok;
    logic                overflow;
    logic                underflow;
    logic                pre_hit;

    // One extra bit keeps out+step and min+step from wrapping silently.
    always_comb begin
        up_sum    = {1'b0, out} + {1'b0, step};
        dn_lim    = {1'b0, min_val} + {1'b0, step};
        bounds_ok = (min_val <= max_val);
        overflow  = (up_sum > {1'b0, max_val});
        underflow = ({1'b0, out} < dn_lim);
    end

`ifdef COUNTER_PRESCALE_EN
    localparam int PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    logic [PW-1:0] pre;

    assign pre_hit = (pre == PW'(PRESCALE - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre <= '0;
        end else if (clear || load) begin
            pre <= '0;
        end else if (en) begin
            pre <= pre_hit ? '0 : pre + 1'b1;
        end
    end
`else
    assign pre_hit = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out <= DATA_WIDTH'(RESET_VAL);
            tc  <= 1'b0;
            sat <= 1'b0;
        end else if (clear) begin
            out <= min_val;
            tc  <= 1'b0;
            sat <= 1'b0;
        end else if (load) begin
            out <= load_val;
            tc  <= 1'b0;
            sat <= 1'b0;
        end else if (en && bounds_ok && pre_hit) begin
            tc <= 1'b0;
            // A zero step is a count event that never crosses a bound.
            if (step == '0) begin
                sat <= 1'b0;
            end else if (dir) begin
                if (!overflow) begin
                    out <= up_sum[DATA_WIDTH-1:0];
                    sat <= 1'b0;
                end else begin
                    tc <= 1'b1;
                    if (wrap) begin
                        out <= min_val;
                    end else begin
                        out <= max_val;
                        sat <= 1'b1;
                    end
                end
            end else begin
                if (!underflow) begin
                    out <= out - step;
                    sat <= 1'b0;
                end else begin
                    tc <= 1'b1;
                    if (wrap) begin
                        out <= max_val;
                    end else begin
                        out <= min_val;
                        sat <= 1'b1;
                    end
                end
            end
        end else begin
            tc <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mode_counter.sv
// tb/tb_mode_counter.sv - directed and randomized checks of mode_counter against an integer model
module tb_mode_counter;

    localparam int DW  = 8;
    localparam int RV  = 7;
    localparam int PSC = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          en, clear, load, dir, wrap;
    logic [DW-1:0] load_val, step, min_val, max_val;
    logic [DW-1:0] out;
    logic          tc, sat;

    int checks   = 0;
    int failures = 0;

    int m_out, m_tc, m_sat, m_pre;

    always #5 clk = ~clk;

    mode_counter #(.DATA_WIDTH(DW), .RESET_VAL(RV), .PRESCALE(PSC)) dut (
        .clk(clk), .rst(rst), .en(en), .clear(clear), .load(load),
        .load_val(load_val), .dir(dir), .step(step), .min_val(min_val),
        .max_val(max_val), .wrap(wrap), .out(out), .tc(tc), .sat(sat)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference behaviour in plain integer arithmetic on the current inputs.
    task automatic model_update();
        int  lo, hi, s;
        bit  ev;
        lo = int'(min_val);
        hi = int'(max_val);
        s  = int'(step);
        if (clear) begin
            m_out = lo; m_tc = 0; m_sat = 0; m_pre = 0;
        end else if (load) begin
            m_out = int'(load_val); m_tc = 0; m_sat = 0; m_pre = 0;
        end else begin
            m_tc = 0;
            ev   = en;
`ifdef COUNTER_PRESCALE_EN
            if (en) begin
                m_pre = m_pre + 1;
                if (m_pre == PSC) m_pre = 0;
                else ev = 0;
            end
`endif
            if (ev && lo <= hi) begin
                if (s == 0) begin
                    m_sat = 0;
                end else if (dir) begin
                    if (m_out + s <= hi) begin
                        m_out = m_out + s; m_sat = 0;
                    end else begin
                        m_tc = 1;
                        if (wrap) m_out = lo;
                        else begin m_out = hi; m_sat = 1; end
                    end
                end else begin
                    if (m_out >= lo + s) begin
                        m_out = m_out - s; m_sat = 0;
                    end else begin
                        m_tc = 1;
                        if (wrap) m_out = hi;
                        else begin m_out = lo; m_sat = 1; end
                    end
                end
            end
        end
    endtask

    task automatic model_reset();
        m_out = RV; m_tc = 0; m_sat = 0; m_pre = 0;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".out"}, 32'(out), 32'(m_out));
        check({tag, ".tc"},  32'(tc),  32'(m_tc));
        check({tag, ".sat"}, 32'(sat), 32'(m_sat));
    endtask

    task automatic tick(input string tag);
        model_update();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    initial begin
        rst = 1'b0; en = 0; clear = 0; load = 0; dir = 1; wrap = 1;
        load_val = '0; step = 8'd1; min_val = '0; max_val = 8'd255;
        model_reset();
        #12;
        check_all("reset");
        check("reset.val", 32'(out), 32'(RV));
        @(negedge clk);
        rst = 1'b1;
        tick("first");

        // up-wrap
        min_val = 2; max_val = 9; step = 3; wrap = 1; dir = 1;
        load = 1; load_val = 2; tick("t1.load");
        load = 0; en = 1;
        tick("t1.a"); check("t1.a.k", 32'(out), 5);
        tick("t1.b"); check("t1.b.k", 32'(out), 8);
        tick("t1.c"); check("t1.c.k", 32'(out), 2); check("t1.c.tc", 32'(tc), 1);
        tick("t1.d"); check("t1.d.tc", 32'(tc), 0);

        // down-saturate
        wrap = 0; dir = 0; en = 0; load = 1; load_val = 4; tick("t2.load");
        load = 0; en = 1;
        tick("t2.a"); check("t2.a.k", 32'(out), 2); check("t2.a.tc", 32'(tc), 1); check("t2.a.sat", 32'(sat), 1);
        tick("t2.b"); check("t2.b.k", 32'(out), 2); check("t2.b.tc", 32'(tc), 1);

        // priority: clear beats load and count
        min_val = 5; clear = 1; load = 1; load_val = 8'd200; en = 1;
        tick("t3"); check("t3.k", 32'(out), 5); check("t3.sat", 32'(sat), 0);
        clear = 0; load = 0;

        // width edge, no modular wrap
        min_val = 0; max_val = 255; dir = 1; wrap = 0; step = 10; en = 0;
        load = 1; load_val = 250; tick("t4.load");
        load = 0; en = 1;
        tick("t4"); check("t4.k", 32'(out), 255); check("t4.sat", 32'(sat), 1);

        // step = 0 never moves or terminates
        step = 0; tick("t5.step0"); check("t5.tc", 32'(tc), 0);

        // prescale / plain count run
        step = 1; wrap = 1; en = 0; load = 1; load_val = 0; tick("t6.load");
        load = 0; en = 1;
        for (int i = 0; i < 12; i++) tick("t6");
`ifdef COUNTER_PRESCALE_EN
        check("t6.k", 32'(out), 3);
`else
        check("t6.k", 32'(out), 12);
`endif

        // async reset between edges
        tick("t7.pre");
        #2 rst = 1'b0;
        #1;
        model_reset();
        check("t7.async.out", 32'(out), 32'(RV));
        check("t7.async.tc", 32'(tc), 0);
        check("t7.async.sat", 32'(sat), 0);
        @(posedge clk); #1; check_all("t7.held");
        @(negedge clk); rst = 1'b1;
        tick("t7.resume");

        // randomized run against the model
        for (int i = 0; i < 600; i++) begin
            if (i % 32 == 0) begin
                int a, b;
                a = $urandom_range(0, 255);
                b = $urandom_range(0, 255);
                if ($urandom_range(0, 7) == 0) begin
                    min_val = DW'(a); max_val = DW'(b);
                end else begin
                    min_val = DW'((a < b) ? a : b);
                    max_val = DW'((a < b) ? b : a);
                end
            end
            clear    = ($urandom_range(0, 15) == 0);
            load     = ($urandom_range(0, 11) == 0);
            load_val = DW'($urandom_range(0, 255));
            en       = ($urandom_range(0, 3) != 0);
            dir      = $urandom_range(0, 1);
            wrap     = $urandom_range(0, 1);
            step     = ($urandom_range(0, 3) == 0) ? DW'($urandom_range(0, 255))
                                                   : DW'($urandom_range(0, 4));
            tick("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
